// File: rtl/cbrt_seq.sv
// Sequential integer cube root: root = floor(a^(1/3)), one root bit per STEP/MUL/UPDATE pass.
// Optional remainder output (a - root^3) is enabled by defining CBRT_REM_EN.
module cbrt_seq #(
    parameter  int WIDTH = 32,
    localparam int RW    = (WIDTH + 2) / 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    root
`ifdef CBRT_REM_EN
    ,
    output logic [WIDTH-1:0] rem
`endif
);

    localparam int AW = 2 * RW + 2;
    localparam int TW = 5 * RW + 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;
    localparam int SW = $clog2(3 * RW);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_MUL    = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;
    logic [RW-1:0]    y_q;
    logic [SW-1:0]    s_q;
    logic [CW-1:0]    bcnt_q;
    logic [CW-1:0]    mcnt_q;
    logic [AW-1:0]    m_q;
    logic [RW-1:0]    n_q;
    logic [AW-1:0]    acc_q;
    logic             busy_q;
    logic             done_q;
    logic [RW-1:0]    root_q;
`ifdef CBRT_REM_EN
    logic [WIDTH-1:0] rem_q;
`endif

    logic [RW-1:0]    y_sh_d;
    logic [AW-1:0]    m_init_d;
    logic [TW-1:0]    t_d;
    logic [TW-1:0]    x_ext_d;
    logic             fits_d;
    logic [WIDTH-1:0] x_upd_d;
    logic [RW-1:0]    y_upd_d;

    // Trial term t = (3y^2+3y+1) << s, kept wide enough that no bit is lost before the compare.
    always_comb begin
        y_sh_d   = y_q << 1;
        m_init_d = AW'({2'b00, y_sh_d}) + AW'({1'b0, y_sh_d, 1'b0});
        t_d      = (TW'(acc_q) + TW'(1)) << s_q;
        x_ext_d  = TW'(x_q);
        fits_d   = (t_d <= x_ext_d);
        if (fits_d) begin
            x_upd_d = x_q - t_d[WIDTH-1:0];
            y_upd_d = y_q + RW'(1);
        end else begin
            x_upd_d = x_q;
            y_upd_d = y_q;
        end
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            m_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            root_q  <= '0;
`ifdef CBRT_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q     <= a;
                        y_q     <= '0;
                        s_q     <= SW'(3 * (RW - 1));
                        bcnt_q  <= CW'(RW - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_STEP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_STEP: begin
                    y_q     <= y_sh_d;
                    m_q     <= m_init_d;
                    n_q     <= y_sh_d + RW'(1);
                    acc_q   <= '0;
                    mcnt_q  <= '0;
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    if (n_q[0]) begin
                        acc_q <= acc_q + m_q;
                    end else begin
                        acc_q <= acc_q;
                    end
                    m_q <= m_q << 1;
                    n_q <= n_q >> 1;
                    if (mcnt_q == CW'(RW - 1)) begin
                        state_q <= S_UPDATE;
                    end else begin
                        mcnt_q  <= mcnt_q + CW'(1);
                    end
                end
                S_UPDATE: begin
                    x_q <= x_upd_d;
                    y_q <= y_upd_d;
                    if (bcnt_q != '0) begin
                        s_q     <= s_q - SW'(3);
                        bcnt_q  <= bcnt_q - CW'(1);
                        state_q <= S_STEP;
                    end else begin
                        root_q  <= y_upd_d;
`ifdef CBRT_REM_EN
                        rem_q   <= x_upd_d;
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign root = root_q;
`ifdef CBRT_REM_EN
    assign rem  = rem_q;
`endif

endmodule

// File: tb/tb_cbrt_seq.sv
// Directed bench for cbrt_seq: 32-bit vector table plus multi-cycle corner sequences,
// and an exhaustive 8-bit instance.
module tb_cbrt_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [10:0] root;
    logic [31:0] rem;

    logic        start8;
    logic [7:0]  a8;
    logic        busy8;
    logic        done8;
    logic [2:0]  root8;
    logic [7:0]  rem8;

    int total = 0;
    int bad   = 0;

    cbrt_seq #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .root  (root)
`ifdef CBRT_REM_EN
        ,
        .rem   (rem)
`endif
    );

    cbrt_seq #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .a     (a8),
        .busy  (busy8),
        .done  (done8),
        .root  (root8)
`ifdef CBRT_REM_EN
        ,
        .rem   (rem8)
`endif
    );

`ifndef CBRT_REM_EN
    assign rem  = 32'd0;
    assign rem8 = 8'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [10:0] root;
        logic [31:0] rem;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic accept32(input logic [31:0] av);
        @(negedge clk);
        a     = av;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done; optionally pulses start with pa at edge T0+pulse_at.
    task automatic wait32(input int pulse_at, input logic [31:0] pa, output int lat, output int bhi);
        lat = 0;
        bhi = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 1000) begin
            if (pulse_at > 0 && lat == pulse_at - 1) begin
                start = 1'b1;
                a     = pa;
            end
            @(posedge clk);
            #1;
            lat++;
            if (pulse_at > 0 && lat == pulse_at) start = 1'b0;
            if (busy === 1'b1) bhi++;
        end
    endtask

    initial begin
        int lat;
        int bhi;
        int r;
        bit saw_done;

        vecs[0] = '{a: 32'd27,         root: 11'd3,    rem: 32'd0};
        vecs[1] = '{a: 32'd0,          root: 11'd0,    rem: 32'd0};
        vecs[2] = '{a: 32'd1,          root: 11'd1,    rem: 32'd0};
        vecs[3] = '{a: 32'd26,         root: 11'd2,    rem: 32'd18};
        vecs[4] = '{a: 32'd1000000,    root: 11'd100,  rem: 32'd0};
        vecs[5] = '{a: 32'hFFFFFFFF,   root: 11'd1625, rem: 32'd3951670};

        reset  = 1'b1;
        start  = 1'b0;
        a      = 32'd0;
        start8 = 1'b0;
        a8     = 8'd0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_root", 64'(root), 64'd0);
        check("reset_rem",  64'(rem),  64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            accept32(vecs[i].a);
            wait32(0, 32'd0, lat, bhi);
            check("vec_latency", 64'(lat), 64'd143);
            check("vec_busy_cycles", 64'(bhi), 64'd143);
            check("vec_root", 64'(root), 64'(vecs[i].root));
`ifdef CBRT_REM_EN
            check("vec_rem", 64'(rem), 64'(vecs[i].rem));
`endif
            @(posedge clk);
            #1;
            check("done_one_cycle", 64'(done), 64'd0);
        end

        // Restart attempt while busy must be ignored.
        accept32(32'd1000);
        wait32(50, 32'd27, lat, bhi);
        check("ignore_latency", 64'(lat), 64'd143);
        check("ignore_root", 64'(root), 64'd10);
        @(posedge clk);
        #1;
        check("ignore_no_restart", 64'(busy), 64'd0);

        // Asynchronous reset mid-MUL aborts without a done pulse.
        accept32(32'd1000000);
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_root", 64'(root), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (160) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("abort_quiet", 64'(saw_done), 64'd0);
        accept32(32'd64);
        wait32(0, 32'd0, lat, bhi);
        check("after_abort_latency", 64'(lat), 64'd143);
        check("after_abort_root", 64'(root), 64'd4);

        // start held through done: back-to-back with zero gap.
        @(negedge clk);
        a     = 32'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd125;
        wait32(0, 32'd0, lat, bhi);
        check("b2b_first_latency", 64'(lat), 64'd143);
        check("b2b_first_root", 64'(root), 64'd2);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy_again", 64'(busy), 64'd1);
        check("b2b_done_low", 64'(done), 64'd0);
        wait32(0, 32'd0, lat, bhi);
        check("b2b_second_latency", 64'(lat), 64'd143);
        check("b2b_second_root", 64'(root), 64'd5);

        // Exhaustive 8-bit sweep.
        for (int v = 0; v < 256; v++) begin
            r = 0;
            while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
            @(negedge clk);
            a8     = 8'(v);
            start8 = 1'b1;
            @(posedge clk);
            #1;
            start8 = 1'b0;
            lat = 0;
            while (done8 !== 1'b1 && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("w8_latency", 64'(lat), 64'd15);
            check("w8_root", 64'(root8), 64'(r));
`ifdef CBRT_REM_EN
            check("w8_rem", 64'(rem8), 64'(v - r * r * r));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
